// File: rtl/fp16_to_int_converter_pkg.sv
// -----------------------------------------------------------------------------
// fp16_to_int_converter_pkg
// Shared constants and types for the FP16 -> int16 converter:
//   - FP16 field positions/widths, exponent bias and the all-ones exponent
//   - int16 saturation limits
//   - converter FSM state encoding and shift direction
//   - small helper for the saturated result of an out-of-range input
// -----------------------------------------------------------------------------
package fp16_to_int_converter_pkg;

    // FP16 layout: sign[15], exponent[14:10], mantissa[9:0]
    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MANT_MSB = 9;
    localparam int MANT_LSB = 0;
    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;

    localparam logic [4:0] EXP_BIAS    = 5'd15;
    localparam logic [4:0] EXP_SPECIAL = 5'd31;
    // Smallest exponent whose magnitude is always >= 32768.
    localparam logic [4:0] EXP_RANGE_LIMIT = 5'd30;
    // Exponent at which the 11-bit significand is already an integer
    // (bias + mantissa width): below it we shift right, above it left.
    localparam logic [4:0] EXP_UNITY_SHIFT = 5'd25;

    localparam logic [15:0] INT16_MAX = 16'h7FFF;
    localparam logic [15:0] INT16_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } shift_dir_e;

    // Saturated int16 for a value beyond the representable range.
    function automatic logic [15:0] saturate_value(input logic sign);
        logic [15:0] result;
        if (sign) begin
            result = INT16_MIN;
        end else begin
            result = INT16_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/fp16_to_int_converter_if.sv
// -----------------------------------------------------------------------------
// fp16_to_int_converter_if
// Request/result bundle of the FP16 -> int16 converter.
//   start, x                                 : request side (master drives)
//   r, busy, done, negative, cout, overflow, zero : result side (slave drives)
// -----------------------------------------------------------------------------
interface fp16_to_int_converter_if;
    logic        start;
    logic [15:0] x;
    logic [15:0] r;
    logic        busy;
    logic        done;
    logic        negative;
    logic        cout;
    logic        overflow;
    logic        zero;

    modport master (
        output start, x,
        input  r, busy, done, negative, cout, overflow, zero
    );

    modport slave (
        input  start, x,
        output r, busy, done, negative, cout, overflow, zero
    );
endinterface

// File: rtl/fp16_to_int_converter_complimenter_2.sv
// -----------------------------------------------------------------------------
// complimenter_2
// Conditional two's-complement stage (combinational).
//   data_in  [WIDTH] : operand
//   enable           : 1 -> data_out = -data_in, 0 -> data_out = data_in
//   data_out [WIDTH] : result (the most negative value maps to itself)
// -----------------------------------------------------------------------------
module complimenter_2 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic [WIDTH-1:0] data_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Invert-and-increment when enabled, pass through otherwise.
    always_comb begin
        data_out = data_in;
        if (enable) begin
            data_out = (~data_in) + ONE;
        end else begin
            data_out = data_in;
        end
    end

endmodule

// File: rtl/fp16_to_int_converter.sv
// -----------------------------------------------------------------------------
// fp16_to_int_converter
// Sequential FP16 -> int16 converter, rounding toward zero.
// The 11-bit significand is aligned one bit per cycle in a 16-bit register,
// then conditionally negated by complimenter_2.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of fp16_to_int_converter_if
//            start/x in; r, busy, done, negative, cout, overflow, zero out
// Parameter NAN_RESULT: integer returned for NaN inputs.
// -----------------------------------------------------------------------------
module fp16_to_int_converter
    import fp16_to_int_converter_pkg::*;
#(
    parameter logic [15:0] NAN_RESULT = 16'h7FFF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fp16_to_int_converter_if.slave      bus
);

    state_e      state_q,  state_d;
    logic [15:0] acc_q,    acc_d;
    logic [3:0]  cnt_q,    cnt_d;
    shift_dir_e  dir_q,    dir_d;
    logic        sign_q,   sign_d;
    logic [15:0] r_q,      r_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        neg_q,    neg_d;
    logic        ovf_q,    ovf_d;
    logic        zero_q,   zero_d;

    logic        in_sign_s;
    logic [4:0]  in_exp_s;
    logic [9:0]  in_mant_s;
    logic [4:0]  left_amt_s;
    logic [4:0]  right_amt_s;
    logic [15:0] negated_s;

    assign in_sign_s   = bus.x[SIGN_BIT];
    assign in_exp_s    = bus.x[EXP_MSB:EXP_LSB];
    assign in_mant_s   = bus.x[MANT_MSB:MANT_LSB];
    // Only one of these is meaningful for a given exponent; the other wraps.
    assign left_amt_s  = in_exp_s - EXP_UNITY_SHIFT;
    assign right_amt_s = EXP_UNITY_SHIFT - in_exp_s;

    complimenter_2 #(
        .WIDTH    (16)
    ) u_negate (
        .data_in  (acc_q),
        .enable   (sign_q),
        .data_out (negated_s)
    );

    // Next-state, datapath and flag computation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        sign_d  = sign_q;
        r_d     = r_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d = in_sign_s;
                    if (in_exp_s == EXP_SPECIAL) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                        if (in_mant_s != 10'd0) begin
                            r_d = NAN_RESULT;
                        end else begin
                            r_d = saturate_value(in_sign_s);
                        end
                    end else if (in_exp_s >= EXP_RANGE_LIMIT) begin
                        // -32768 is the only in-range value at this magnitude;
                        // it goes through the negator, which maps 0x8000 to itself.
                        if (in_sign_s && (in_exp_s == EXP_RANGE_LIMIT) && (in_mant_s == 10'd0)) begin
                            acc_d   = INT16_MIN;
                            state_d = NEGATE;
                        end else begin
                            r_d     = saturate_value(in_sign_s);
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end
                    end else if (in_exp_s < EXP_BIAS) begin
                        r_d     = 16'h0000;
                        ovf_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        acc_d = {5'b00000, 1'b1, in_mant_s};
                        if (in_exp_s >= EXP_UNITY_SHIFT) begin
                            dir_d = DIR_LEFT;
                            cnt_d = left_amt_s[3:0];
                        end else begin
                            dir_d = DIR_RIGHT;
                            cnt_d = right_amt_s[3:0];
                        end
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            SHIFT: begin
                if (cnt_q != 4'd0) begin
                    if (dir_q == DIR_LEFT) begin
                        acc_d = {acc_q[14:0], 1'b0};
                    end else begin
                        acc_d = {1'b0, acc_q[15:1]};
                    end
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = NEGATE;
                end
            end

            NEGATE: begin
                r_d     = negated_s;
                ovf_d   = 1'b0;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Sign/zero flags follow the result and change only on entry to DONE.
        if ((state_d == DONE) && (state_q != DONE)) begin
            neg_d  = r_d[15];
            zero_d = (r_d == 16'h0000);
        end else begin
            neg_d  = neg_q;
            zero_d = zero_q;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            dir_q   <= DIR_RIGHT;
            sign_q  <= 1'b0;
            r_q     <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            sign_q  <= sign_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.r        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.negative = neg_q;
    assign bus.cout     = 1'b0;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_fp16_to_int_converter.sv
// -----------------------------------------------------------------------------
// tb_fp16_to_int_converter
// Scoreboard bench: the driver pushes the reference-model result of every
// accepted request; a monitor pops and compares on each done pulse.
// -----------------------------------------------------------------------------
module tb_fp16_to_int_converter;

    logic clk;
    logic rst_n;

    fp16_to_int_converter_if bus ();

    fp16_to_int_converter #(
        .NAN_RESULT (16'h7FFF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] r;
        logic        neg;
        logic        ovf;
        logic        zero;
        int          lat;
        int          issue;
        bit          has_v;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ncyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: at a falling edge it holds the index of the current cycle.
    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic real pow2(input int k);
        real p;
        p = 1.0;
        if (k >= 0) begin
            for (int i = 0; i < k; i++) p = p * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) p = p / 2.0;
        end
        return p;
    endfunction

    // Reference: value = (-1)^s * sig * 2^(E-25), truncated toward zero,
    // saturated to int16; latency from the documented cycle counts.
    function automatic exp_t model(input logic [15:0] xv);
        exp_t   e;
        int     ex;
        int     mt;
        real    val;
        int     iv;
        logic [31:0] iv32;
        ex = int'(xv[14:10]);
        mt = int'(xv[9:0]);
        e.x = xv; e.has_v = 1'b0; e.v = 16'h0000; e.issue = 0;
        e.ovf = 1'b0;
        if (ex == 31) begin
            e.ovf = 1'b1;
            e.lat = 1;
            if (mt != 0) e.r = 16'h7FFF;
            else         e.r = xv[15] ? 16'h8000 : 16'h7FFF;
        end else begin
            if (ex == 0) val = real'(mt) * pow2(1 - 25);
            else         val = real'(1024 + mt) * pow2(ex - 25);
            if (xv[15]) val = -val;
            if (val >= 32768.0) begin
                e.r = 16'h7FFF; e.ovf = 1'b1; e.lat = 1;
            end else if (val < -32768.0) begin
                e.r = 16'h8000; e.ovf = 1'b1; e.lat = 1;
            end else if (val == -32768.0) begin
                e.r = 16'h8000; e.lat = 2;
            end else begin
                iv   = $rtoi(val);
                iv32 = iv;
                e.r  = iv32[15:0];
                if (val < 1.0 && val > -1.0) e.lat = 1;
                else e.lat = ((ex > 25) ? (ex - 25) : (25 - ex)) + 3;
            end
        end
        e.neg  = e.r[15];
        e.zero = (e.r == 16'h0000);
        return e;
    endfunction

    // Int16 -> FP16 keeping the top 11 significant bits (truncation).
    function automatic logic [15:0] int_to_fp16_trunc(input logic [15:0] v);
        int          sv;
        int          mag;
        int          p;
        int          m;
        logic [31:0] e32;
        logic [31:0] m32;
        sv = int'($signed(v));
        if (sv == 0) return 16'h0000;
        mag = (sv < 0) ? -sv : sv;
        p = 0;
        for (int i = 0; i < 17; i++) if ((mag >> i) != 0) p = i;
        if (p >= 10) m = (mag >> (p - 10)) & 1023;
        else         m = (mag << (10 - p)) & 1023;
        e32 = p + 15;
        m32 = m;
        return {v[15], e32[4:0], m32[9:0]};
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected no pending request (cycle %0d)", ncyc);
            end else begin
                exp_t e;
                int   rv;
                int   vv;
                e = sb.pop_front();
                chk($sformatf("r x=%04h", e.x), {16'h0, bus.r}, {16'h0, e.r});
                chk($sformatf("negative x=%04h", e.x), {31'h0, bus.negative}, {31'h0, e.neg});
                chk($sformatf("overflow x=%04h", e.x), {31'h0, bus.overflow}, {31'h0, e.ovf});
                chk($sformatf("zero x=%04h", e.x), {31'h0, bus.zero}, {31'h0, e.zero});
                chk($sformatf("cout x=%04h", e.x), {31'h0, bus.cout}, 32'h0);
                chk($sformatf("busy_in_done x=%04h", e.x), {31'h0, bus.busy}, 32'h1);
                chk($sformatf("latency x=%04h", e.x), ncyc - e.issue, e.lat);
                if (e.has_v) begin
                    rv = int'($signed(bus.r));
                    vv = int'($signed(e.v));
                    chk($sformatf("rt_mag v=%04h", e.v),
                        {31'h0, ((rv < 0 ? -rv : rv) <= (vv < 0 ? -vv : vv))}, 32'h1);
                    chk($sformatf("rt_sign v=%04h", e.v),
                        {31'h0, ((rv == 0) || ((rv < 0) == (vv < 0)))}, 32'h1);
                end
            end
        end
    end

    // Issue one request at a falling edge and wait (bounded) for its done.
    task automatic run(input logic [15:0] xv, input bit noise, input bit has_v, input logic [15:0] v);
        exp_t        e;
        bit          got;
        logic [31:0] rnd;
        @(negedge clk);
        e       = model(xv);
        e.issue = ncyc;
        e.has_v = has_v;
        e.v     = v;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.x     = xv;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            rnd       = $urandom;
            bus.start = noise;
            bus.x     = rnd[15:0];
        end
        bus.start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout x=%04h: got no done expected done within 40 cycles", xv);
            if (sb.size() != 0) void'(sb.pop_front());
        end
    endtask

    logic [15:0] dir_tab [0:9] = '{16'h3C00, 16'hC500, 16'h5640, 16'hF800, 16'h7800,
                                   16'h3800, 16'h8000, 16'h7E00, 16'hFC00, 16'h7C00};

    initial begin
        logic [31:0] rnd;
        logic [15:0] xv;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.x     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_r",        {16'h0, bus.r},        32'h0);
        chk("reset_busy",     {31'h0, bus.busy},     32'h0);
        chk("reset_done",     {31'h0, bus.done},     32'h0);
        chk("reset_negative", {31'h0, bus.negative}, 32'h0);
        chk("reset_cout",     {31'h0, bus.cout},     32'h0);
        chk("reset_overflow", {31'h0, bus.overflow}, 32'h0);
        chk("reset_zero",     {31'h0, bus.zero},     32'h0);
        rst_n = 1'b1;

        foreach (dir_tab[i]) run(dir_tab[i], 1'b0, 1'b0, 16'h0000);

        // start held high with changing x throughout a long conversion
        run(16'h3C00, 1'b1, 1'b0, 16'h0000);

        // reset pulse in cycle 5 of a conversion: no done, outputs cleared
        @(negedge clk);
        bus.start = 1'b1;
        bus.x     = 16'h3C00;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_r",    {16'h0, bus.r},    32'h0);
        chk("midreset_busy", {31'h0, bus.busy}, 32'h0);
        chk("midreset_done", {31'h0, bus.done}, 32'h0);
        chk("midreset_ovf",  {31'h0, bus.overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_idle", {31'h0, bus.busy}, 32'h0);

        // random FP16 operands, exponent drawn uniformly
        for (int i = 0; i < 250; i++) begin
            rnd = $urandom;
            xv  = rnd[15:0];
            run(xv, rnd[16], 1'b0, 16'h0000);
        end

        // round trip through a truncating int16 -> FP16 conversion
        for (int i = 0; i < 120; i++) begin
            rnd = $urandom;
            if (i == 0)      xv = 16'h8000;
            else if (i == 1) xv = 16'h7FFF;
            else if (i == 2) xv = 16'h0000;
            else             xv = rnd[15:0];
            run(int_to_fp16_trunc(xv), 1'b0, 1'b1, xv);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_to_int_converter.md
Name: fp16_to_int_converter

Overview:
- Sequential converter from IEEE-754 half-precision (1/5/10) to a 16-bit two's-complement integer, rounding toward zero.
- It is the return path for the combinational integer-to-FP16 stage. It consumes FP16 words that the ALU produces and hands integer results back to the integer datapath.
- The magnitude is aligned one bit per cycle using a single 16-bit shift register, which keeps the area small. The block reports the same flag set as the other ALU operations.

Parameters:
- NAN_RESULT, 16'h7FFF, integer result returned for NaN inputs.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- x  input  16  FP16 operand; captured on the edge that accepts start.
- r  output  16  integer result; valid while done=1, held until the next accept.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; r and the flags are valid in this cycle.
- negative  output  1  r[15].
- cout  output  1  always 0.
- overflow  output  1  set when the result saturated (out of range, Inf, or NaN).
- zero  output  1  r == 0.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; r, busy, done, negative, cout, overflow, zero are all 0. Reset asserted mid-operation aborts the conversion with no done pulse.
- Decode: s=x[15], E=x[14:10], M=x[9:0], sig={1,M} (11 bits), e=E-15.
- States: IDLE, SHIFT, NEGATE, DONE.
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. On the edge ending cycle 0, x is captured and classified:
  - E==31, M!=0 (NaN): load r=NAN_RESULT, overflow=1, go to DONE.
  - E==31, M==0 (Inf): r=s?16'h8000:16'h7FFF, overflow=1, go to DONE.
  - E>=30: if s=1, E==30 and M==0, the value is exactly -32768. Load the magnitude accumulator acc=16'h8000 and go to NEGATE (negation of 0x8000 yields 0x8000, overflow=0). Otherwise the input is out of range: r=s?16'h8000:16'h7FFF, overflow=1, go to DONE.
  - E<15 (|x|<1, including ±0 and subnormals): r=0, zero=1, negative=0, go to DONE. -0.5 therefore gives r=0, negative=0.
  - Otherwise: acc={5'b0,sig}, dir=(e>=10)?left:right, cnt=|e-10| (range 0..10), go to SHIFT.
- SHIFT:
  - Each edge with cnt!=0 shifts acc one bit in direction dir and decrements cnt.
  - The edge with cnt==0 moves to NEGATE.
  - Bits shifted out on the right are discarded (truncation). Left shifts cannot lose set bits for E<=29.
- NEGATE: on the edge, r = s ? two's-complement(acc) : acc. Flags are computed from that r. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; then go to IDLE. r and the flags hold until the next accept.
- Latency:
  - Normal path: done=1 in cycle cnt+3 (SHIFT occupies cycles 1..cnt+1, NEGATE is cycle cnt+2).
  - Special cases (NaN, Inf, out of range, |x|<1): done=1 in cycle 1.
  - -32768 path: done=1 in cycle 2.
- start while busy (including DONE) is ignored and not queued. Changes on x after the accept have no effect.
- Flags are updated only on the edge entering DONE. cout never changes from 0.

Decomposition:
- Shared package (alu_pkg or fp16_pkg) holds:
  - FP16 field widths and positions (SIGN_BIT=15, EXP 14:10, MANT 9:0), EXP_BIAS=15, EXP_SPECIAL=5'd31.
  - INT16_MAX=16'h7FFF, INT16_MIN=16'h8000.
  - The state enum {IDLE, SHIFT, NEGATE, DONE}.
- Negation reuses the existing complimenter_2 (WIDTH=16, enable=s) as the one sub-module. The FSM, classifier and shifter stay in this module.

Test Plan:
- x=16'h3C00 (1.0): cnt=10 -> r=16'h0001, done in cycle 13, flags all 0.
- x=16'hC500 (-5.0): cnt=8 -> r=16'hFFFB, negative=1, done in cycle 11. x=16'h5640 (100.0): cnt=4 -> r=16'h0064, done in cycle 7.
- x=16'hF800 (-32768): -32768 path -> r=16'h8000, negative=1, overflow=0, done in cycle 2. x=16'h7800 (+32768) -> r=16'h7FFF, overflow=1, done in cycle 1.
- x=16'h3800 (0.5) and x=16'h8000 (-0): r=0, zero=1, negative=0, done in cycle 1. x=16'h7E00 (NaN): r=16'h7FFF, overflow=1. x=16'hFC00 (-Inf): r=16'h8000, overflow=1.
- Assert start again at cycles 1..12 during the 1.0 conversion -> ignored, exactly one done pulse. Pulse rst_n low in cycle 5 -> outputs 0, state IDLE, no done.
- Round trip: every int16 v through the int-to-FP16 stage then this block gives r = v truncated toward zero at FP16 precision, with |r| <= |v| and the sign preserved.
